sar_bit_collector: RTL and testbench
====================================

Name: sar_bit_collector

Overview:
Consumer end of the SAR conversion-control interface. Takes the sample-start strobe SARRST and one-hot bit-decision strobes from the conversion-sequencing FSM, together with the comparator output VCOMP. Maintains the SAR trial/result register that drives the capacitive DAC, and assembles each finished code into an output word. The word is delivered through a valid/ready handshake to downstream digital logic, with overflow and sequence-error flags.

Parameters:
NBITS, 4, conversion resolution; width of BITEN, DAC and DOUT.
AVG_LOG2, 2, log2 of the number of conversions averaged; used only when SAR_AVG_EN is defined.

Ports:
CLK  input  1  clock, rising edge.
RESET  input  1  synchronous, active-high reset.
SARRST  input  1  sample phase; starts a new conversion.
BITEN  input  NBITS  one-hot decision strobe; bit k high resolves result bit k.
VCOMP  input  1  comparator output; 1 means Vin >= DAC, so the trial bit is kept.
DAC  output  NBITS  registered trial code to the DAC switches.
DOUT  output  NBITS  completed conversion word.
DVALID  output  1  DOUT holds an unconsumed word.
DREADY  input  1  downstream accepts DOUT.
BUSY  output  1  conversion in progress (SAMPLE or CONVERT).
OVF  output  1  sticky; an unconsumed word was overwritten.
ERR  output  1  sticky; an illegal strobe sequence was detected.

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high. All state updates happen on the CLK rising edge.
- Reset values: DAC=0, DOUT=0, DVALID=0, BUSY=0, OVF=0, ERR=0, state=IDLE, expected index=NBITS-1. RESET mid-conversion aborts the conversion and drops any pending word.
- States:
  - IDLE: BUSY=0.
  - SAMPLE: BUSY=1.
  - CONVERT: BUSY=1.
- SARRST=1 in any state:
  - next state is SAMPLE;
  - DAC <= 1 followed by zeros (MSB only);
  - expected index <= NBITS-1.
  - SARRST has priority over a simultaneous BITEN, and that BITEN is ignored without setting ERR.
- SAMPLE or CONVERT with SARRST=0 and BITEN == one-hot(expected index k):
  - DAC[k] <= VCOMP;
  - if k>0: DAC[k-1] <= 1, expected index <= k-1, state <= CONVERT;
  - if k==0: conversion complete. The final code {DAC[NBITS-1:1], VCOMP} is loaded into DOUT one cycle after the LSB strobe, and DVALID <= 1. State <= IDLE. DAC holds the final code until the next SARRST.
- BITEN == 0: hold all state. Stall cycles between strobes are legal.
- In SAMPLE or CONVERT, BITEN nonzero and not the expected one-hot (wrong index or multi-hot): ERR <= 1, state <= IDLE, DAC <= 0, no word is emitted.
- In IDLE, BITEN nonzero: ERR <= 1, no other effect.
- Handshake:
  - a transfer occurs on a cycle with DVALID=1 and DREADY=1;
  - DVALID falls the following cycle unless a new word loads on that same edge, in which case DVALID stays 1 and no OVF is raised;
  - a new word loading while DVALID=1 and DREADY=0 overwrites DOUT and sets OVF.
- DOUT is stable while DVALID=1 and DREADY=0, except when overwritten as above.
- OVF and ERR clear only on RESET.
- Latency: DVALID rises exactly one cycle after the LSB strobe cycle.

Optional Feature:
SAR_AVG_EN
- Defined:
  - each completed code is added to an accumulator of NBITS+AVG_LOG2 bits, and a conversion counter increments;
  - on the 2^AVG_LOG2-th completion, DOUT <= (accumulator + final code) >> AVG_LOG2 (truncating), DVALID <= 1, and the accumulator and counter clear;
  - intermediate completions do not assert DVALID;
  - an ERR abort does not touch the accumulator;
  - RESET clears the accumulator and counter.
- Undefined: every completed conversion is emitted directly as DOUT, no accumulator exists, and AVG_LOG2 is unused.

Test Plan:
1. NBITS=4, basic conversion:
   - SARRST for 1 cycle -> DAC=1000.
   - BITEN=1000, VCOMP=1 -> DAC=1100.
   - BITEN=0100, VCOMP=0 -> DAC=1010.
   - BITEN=0010, VCOMP=1 -> DAC=1011.
   - BITEN=0001, VCOMP=1 -> next cycle DOUT=1011, DVALID=1, BUSY=0.
2. Backpressure: hold DREADY=0 and run a second conversion with all VCOMP=0 -> DOUT=0000, OVF=1. Then DREADY=1 for 1 cycle -> DVALID=0 the following cycle.
3. Sequence error: SARRST, then BITEN=0100 first -> ERR=1, DAC=0, state IDLE, DVALID unchanged. Multi-hot BITEN=1100 after SARRST -> ERR=1.
4. Priority and stalls: SARRST together with BITEN=1000 -> DAC=1000, ERR=0. Insert 3 idle cycles (BITEN=0) between strobes -> same result as scenario 1.
5. Back-to-back: DREADY tied 1, LSB strobe on the same edge DVALID=1 is accepted -> DVALID stays 1 with the new word, OVF=0. RESET asserted mid-CONVERT -> all outputs 0 the next cycle.
6. SAR_AVG_EN, AVG_LOG2=2: codes 1011, 1011, 1100, 1101 -> exactly one DVALID, DOUT=(11+11+12+13)>>2=1011.

Source files
------------

// File: rtl/sar_bit_collector.sv
// sar_bit_collector: SAR trial/result register with valid/ready word output; define SAR_AVG_EN to emit the mean of 2^AVG_LOG2 conversions
module sar_bit_collector #(
    parameter int NBITS    = 4,
    parameter int AVG_LOG2 = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             SARRST,
    input  logic [NBITS-1:0] BITEN,
    input  logic             VCOMP,
    output logic [NBITS-1:0] DAC,
    output logic [NBITS-1:0] DOUT,
    output logic             DVALID,
    input  logic             DREADY,
    output logic             BUSY,
    output logic             OVF,
    output logic             ERR
);
    localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT} state_t;
    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [NBITS-1:0] dac_q, dac_d, dout_q, dout_d;
    logic             dvalid_q, dvalid_d, ovf_q, ovf_d, err_q, err_d;
    logic [NBITS-1:0] expect_oh, code, word;
    logic             done, load;
    assign expect_oh = {{(NBITS-1){1'b0}}, 1'b1} << idx_q;
    assign code      = {dac_q[NBITS-1:1], VCOMP};
`ifdef SAR_AVG_EN
    localparam int AW = NBITS + AVG_LOG2;
    logic [AW-1:0]       acc_q, acc_d, sum;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;
    assign sum = acc_q + AW'(code);
    // accumulate finished codes; the counter wraps to zero on the emitting completion
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        load  = 1'b0;
        word  = sum[AW-1:AVG_LOG2];
        if (done) begin
            load  = &cnt_q;
            acc_d = load ? '0 : sum;
            cnt_d = cnt_q + AVG_LOG2'(1);
        end
    end
    // accumulator and completion counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end
`else
    assign load = done;
    assign word = code;
`endif
    // conversion sequencing: SARRST wins, expected strobe resolves a bit, anything else is an error
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dac_d   = dac_q;
        err_d   = err_q;
        done    = 1'b0;
        if (SARRST) begin
            state_d = SAMPLE;
            idx_d   = IW'(NBITS-1);
            dac_d   = {1'b1, {(NBITS-1){1'b0}}};
        end else if (BITEN != '0) begin
            if (state_q == IDLE) begin
                err_d = 1'b1;
            end else if (BITEN == expect_oh) begin
                dac_d[idx_q] = VCOMP;
                if (idx_q != '0) begin
                    dac_d[idx_q - IW'(1)] = 1'b1;
                    idx_d   = idx_q - IW'(1);
                    state_d = CONVERT;
                end else begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end else begin
                err_d   = 1'b1;
                state_d = IDLE;
                dac_d   = '0;
            end
        end
    end
    // output word handshake: a load on a transfer edge keeps DVALID high without overflow
    always_comb begin
        dout_d   = load ? word : dout_q;
        dvalid_d = load | (dvalid_q & ~DREADY);
        ovf_d    = ovf_q | (load & dvalid_q & ~DREADY);
    end
    // state registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            idx_q    <= IW'(NBITS-1);
            dac_q    <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dac_q    <= dac_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end
    assign DAC    = dac_q;
    assign DOUT   = dout_q;
    assign DVALID = dvalid_q;
    assign BUSY   = state_q != IDLE;
    assign OVF    = ovf_q;
    assign ERR    = err_q;
endmodule

// File: tb/tb_sar_bit_collector.sv
// tb_sar_bit_collector: scenario and randomized checks of sar_bit_collector against a decision-level model
module tb_sar_bit_collector;
    localparam int N = 4;
    localparam int A = 2;
    logic         CLK, RESET, SARRST, VCOMP, DREADY;
    logic [N-1:0] BITEN, DAC, DOUT;
    logic         DVALID, BUSY, OVF, ERR;
    int checks = 0, errors = 0;
    bit m_conv, m_dv, m_ovf, m_err;
    int m_idx, m_code, m_dac, m_dout, m_sum, m_cnt;

    sar_bit_collector #(.NBITS(N), .AVG_LOG2(A)) dut (
        .CLK(CLK), .RESET(RESET), .SARRST(SARRST), .BITEN(BITEN), .VCOMP(VCOMP),
        .DAC(DAC), .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY),
        .BUSY(BUSY), .OVF(OVF), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic do_reset;
        RESET  = 1;
        SARRST = 1'($urandom);
        BITEN  = N'($urandom);
        VCOMP  = 1'($urandom);
        DREADY = 1'($urandom);
        @(posedge CLK);
        #1;
        RESET  = 0;
        SARRST = 0;
        BITEN  = 0;
        {m_conv, m_dv, m_ovf, m_err} = 0;
        {m_code, m_dac, m_dout, m_sum, m_cnt} = 0;
        m_idx = N - 1;
    endtask

    // drive one cycle and advance the model: the result code is the sum of kept decisions
    task automatic step(input logic s, input logic [N-1:0] b, input logic v, input logic r);
        bit load;
        int word;
        SARRST = s;
        BITEN  = b;
        VCOMP  = v;
        DREADY = r;
        load = 0;
        word = 0;
        if (s) begin
            m_conv = 1;
            m_idx  = N - 1;
            m_code = 0;
        end else if (b != 0) begin
            if (!m_conv) m_err = 1;
            else if (b == N'(1 << m_idx)) begin
                m_code += int'(v) << m_idx;
                if (m_idx > 0) m_idx--;
                else begin
                    m_conv = 0;
`ifdef SAR_AVG_EN
                    m_sum += m_code;
                    m_cnt++;
                    if (m_cnt == (1 << A)) begin
                        load  = 1;
                        word  = m_sum / (1 << A);
                        m_sum = 0;
                        m_cnt = 0;
                    end
`else
                    load = 1;
                    word = m_code;
`endif
                end
            end else begin
                m_err  = 1;
                m_conv = 0;
                m_code = 0;
            end
        end
        if (load) begin
            if (m_dv && !r) m_ovf = 1;
            m_dout = word;
            m_dv   = 1;
        end else if (m_dv && r) m_dv = 0;
        m_dac = m_code + (m_conv ? (1 << m_idx) : 0);
        @(posedge CLK);
        #1;
    endtask

    task automatic convert(input logic [N-1:0] code, input logic r, input logic r_lsb, input int stall);
        step(1, 0, 0, r);
        for (int k = N - 1; k >= 0; k--) begin
            step(0, N'(1 << k), code[k], k == 0 ? r_lsb : r);
            if (k > 0) repeat (stall) step(0, 0, 0, r);
        end
    endtask

    task automatic test_reset;
        do_reset();
        checks += 6;
        if (DAC !== 0) begin errors++; $display("FAIL reset_dac got=%b exp=0000", DAC); end
        if (DOUT !== 0) begin errors++; $display("FAIL reset_dout got=%b exp=0000", DOUT); end
        if (DVALID !== 0) begin errors++; $display("FAIL reset_dvalid got=%b exp=0", DVALID); end
        if (BUSY !== 0) begin errors++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        if (OVF !== 0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", OVF); end
        if (ERR !== 0) begin errors++; $display("FAIL reset_err got=%b exp=0", ERR); end
    endtask

    task automatic test_basic;
        logic [N-1:0] exp_dac [5];
        logic [N-1:0] bt [5];
        logic         vc [5];
        exp_dac = '{4'b1000, 4'b1100, 4'b1010, 4'b1011, 4'b1011};
        bt      = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        vc      = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(i == 0, bt[i], vc[i], 1);
            checks++;
            if (DAC !== exp_dac[i] || BUSY !== (i < 4)) begin
                errors++;
                $display("FAIL basic_step%0d got DAC=%b BUSY=%b exp DAC=%b BUSY=%b", i, DAC, BUSY, exp_dac[i], i < 4);
            end
        end
`ifndef SAR_AVG_EN
        checks++;
        if (DOUT !== 4'b1011 || DVALID !== 1) begin
            errors++;
            $display("FAIL basic_word got DOUT=%b DVALID=%b exp 1011 1", DOUT, DVALID);
        end
`endif
        checks++;
        if (DOUT !== N'(m_dout) || DVALID !== m_dv) begin
            errors++;
            $display("FAIL basic_model got DOUT=%b DVALID=%b exp %b %b", DOUT, DVALID, N'(m_dout), m_dv);
        end
    endtask

    task automatic test_backpressure;
        convert(4'b0000, 0, 0, 0);
        checks++;
        if (DOUT !== N'(m_dout) || DVALID !== m_dv || OVF !== m_ovf) begin
            errors++;
            $display("FAIL bp_model got DOUT=%b DVALID=%b OVF=%b exp %b %b %b", DOUT, DVALID, OVF, N'(m_dout), m_dv, m_ovf);
        end
`ifndef SAR_AVG_EN
        checks++;
        if (DOUT !== 4'b0000 || OVF !== 1 || DVALID !== 1) begin
            errors++;
            $display("FAIL bp_overwrite got DOUT=%b OVF=%b DVALID=%b exp 0000 1 1", DOUT, OVF, DVALID);
        end
`endif
        step(0, 0, 0, 1);
        checks++;
        if (DVALID !== 0) begin errors++; $display("FAIL bp_drain got DVALID=%b exp=0", DVALID); end
        step(0, 0, 0, 0);
    endtask

    task automatic test_seq_error;
        do_reset();
        convert(4'b0110, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 4'b0100, 1, 0);
        checks++;
        if (ERR !== 1 || DAC !== 0 || BUSY !== 0 || DVALID !== m_dv) begin
            errors++;
            $display("FAIL seq_wrong_idx got ERR=%b DAC=%b BUSY=%b DVALID=%b exp 1 0000 0 %b", ERR, DAC, BUSY, DVALID, m_dv);
        end
`ifndef SAR_AVG_EN
        checks++;
        if (DVALID !== 1 || DOUT !== 4'b0110) begin
            errors++;
            $display("FAIL seq_word_kept got DVALID=%b DOUT=%b exp 1 0110", DVALID, DOUT);
        end
`endif
        do_reset();
        step(1, 0, 0, 1);
        step(0, 4'b1100, 1, 1);
        checks++;
        if (ERR !== 1 || DAC !== 0 || BUSY !== 0) begin
            errors++;
            $display("FAIL seq_multihot got ERR=%b DAC=%b BUSY=%b exp 1 0000 0", ERR, DAC, BUSY);
        end
        do_reset();
        step(0, 4'b0010, 1, 1);
        checks++;
        if (ERR !== 1 || DAC !== 0 || BUSY !== 0 || DVALID !== 0) begin
            errors++;
            $display("FAIL seq_idle_strobe got ERR=%b DAC=%b BUSY=%b DVALID=%b exp 1 0000 0 0", ERR, DAC, BUSY, DVALID);
        end
    endtask

    task automatic test_priority_stall;
        do_reset();
        step(1, 4'b1000, 1, 1);
        checks++;
        if (DAC !== 4'b1000 || ERR !== 0 || BUSY !== 1) begin
            errors++;
            $display("FAIL prio_sarrst got DAC=%b ERR=%b BUSY=%b exp 1000 0 1", DAC, ERR, BUSY);
        end
        step(0, 4'b1000, 1, 1);
        repeat (3) step(0, 0, 0, 1);
        checks++;
        if (DAC !== 4'b1100 || BUSY !== 1) begin
            errors++;
            $display("FAIL stall_hold got DAC=%b BUSY=%b exp 1100 1", DAC, BUSY);
        end
        step(0, 4'b0100, 0, 1);
        repeat (3) step(0, 0, 0, 1);
        step(0, 4'b0010, 1, 1);
        repeat (3) step(0, 0, 0, 1);
        step(0, 4'b0001, 1, 1);
        checks++;
        if (DAC !== 4'b1011 || BUSY !== 0 || ERR !== 0 || DOUT !== N'(m_dout) || DVALID !== m_dv) begin
            errors++;
            $display("FAIL stall_result got DAC=%b BUSY=%b ERR=%b DOUT=%b DVALID=%b exp 1011 0 0 %b %b", DAC, BUSY, ERR, DOUT, DVALID, N'(m_dout), m_dv);
        end
`ifndef SAR_AVG_EN
        checks++;
        if (DOUT !== 4'b1011 || DVALID !== 1) begin
            errors++;
            $display("FAIL stall_word got DOUT=%b DVALID=%b exp 1011 1", DOUT, DVALID);
        end
`endif
    endtask

    task automatic test_back_to_back;
        do_reset();
        convert(4'b1011, 1, 1, 0);
        convert(4'b0101, 0, 1, 0);
        checks++;
        if (DOUT !== N'(m_dout) || DVALID !== m_dv || OVF !== m_ovf) begin
            errors++;
            $display("FAIL b2b_model got DOUT=%b DVALID=%b OVF=%b exp %b %b %b", DOUT, DVALID, OVF, N'(m_dout), m_dv, m_ovf);
        end
`ifndef SAR_AVG_EN
        checks++;
        if (DOUT !== 4'b0101 || DVALID !== 1 || OVF !== 0) begin
            errors++;
            $display("FAIL b2b_word got DOUT=%b DVALID=%b OVF=%b exp 0101 1 0", DOUT, DVALID, OVF);
        end
`endif
        step(1, 0, 0, 1);
        step(0, 4'b1000, 1, 1);
        do_reset();
        checks++;
        if ({DAC, DOUT, DVALID, BUSY, OVF, ERR} !== '0) begin
            errors++;
            $display("FAIL reset_mid_convert got DAC=%b DOUT=%b DVALID=%b BUSY=%b OVF=%b ERR=%b exp all 0", DAC, DOUT, DVALID, BUSY, OVF, ERR);
        end
    endtask

    task automatic test_random;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            int p;
            p = int'($urandom_range(99));
            if (p < 1) do_reset();
            else if (p < 3) step(1'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
            else if (!m_conv) step(p < 60, 0, 0, 1'($urandom));
            else if (p < 25) step(0, 0, 1'($urandom), 1'($urandom));
            else step(0, N'(1 << m_idx), 1'($urandom), 1'($urandom));
            checks++;
            if ({DAC, DOUT, DVALID, BUSY, OVF, ERR} !== {N'(m_dac), N'(m_dout), m_dv, m_conv, m_ovf, m_err}) begin
                errors++;
                $display("FAIL rand_cycle%0d got DAC=%b DOUT=%b DVALID=%b BUSY=%b OVF=%b ERR=%b exp %b %b %b %b %b %b",
                         c, DAC, DOUT, DVALID, BUSY, OVF, ERR, N'(m_dac), N'(m_dout), m_dv, m_conv, m_ovf, m_err);
            end
        end
    endtask

`ifdef SAR_AVG_EN
    task automatic test_avg;
        logic [N-1:0] codes [4];
        int           rises;
        codes = '{4'b1011, 4'b1011, 4'b1100, 4'b1101};
        rises = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            convert(codes[i], 0, 0, 0);
            if (DVALID === 1) rises++;
        end
        checks++;
        if (rises !== 1 || DOUT !== 4'b1011 || OVF !== 0) begin
            errors++;
            $display("FAIL avg_word got rises=%0d DOUT=%b OVF=%b exp 1 1011 0", rises, DOUT, OVF);
        end
    endtask
`endif

    initial begin
        CLK    = 0;
        RESET  = 1;
        SARRST = 0;
        BITEN  = 0;
        VCOMP  = 0;
        DREADY = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_seq_error();
        test_priority_stall();
        test_back_to_back();
`ifdef SAR_AVG_EN
        test_avg();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
